// File: rtl/pico_out_bank_pkg.sv
// Shared definitions for the PicoBlaze output-port bank: RTC port indices,
// the commit address and the default set of ports that bypass staging.
package pico_out_bank_pkg;

  // Port indices as seen by the PicoBlaze program
  localparam int PORT_SEG       = 0;
  localparam int PORT_MIN       = 1;
  localparam int PORT_HORA      = 2;
  localparam int PORT_DIA       = 3;
  localparam int PORT_MES       = 4;
  localparam int PORT_YEAR      = 5;
  localparam int PORT_SEG_TIM   = 6;
  localparam int PORT_MIN_TIM   = 7;
  localparam int PORT_HORA_TIM  = 8;
  localparam int PORT_SWT       = 9;
  localparam int PORT_FLECHA    = 10;
  localparam int PORT_OPERACION = 11;

  localparam int N_PORTS_DEFAULT = 12;

  // Writing this address publishes every shadow register at once
  localparam logic [7:0] PORT_COMMIT = 8'hFF;

  // swt, flecha and operacion are live controls, not RTC fields
  localparam logic [11:0] DEFAULT_DIRECT_MASK = 12'hE00;

  // One-hot mask for a port index in the default 12-port map
  function automatic logic [11:0] port_bit(input int idx);
    return 12'h001 << idx;
  endfunction

endpackage

// File: rtl/pico_port_reg.sv
// One output port: a visible register, optionally fronted by a shadow
// register that is only copied to the visible side on commit.
module pico_port_reg #(
  parameter int WIDTH  = 8,
  parameter bit DIRECT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             commit,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] vis_r;

  if (DIRECT) begin : g_direct
    // Direct ports never stage, so the commit strobe has no effect here
    logic unused_commit_s;
    assign unused_commit_s = commit;

    // Direct port: the write lands on the visible register immediately
    always_ff @(posedge clk) begin
      if (reset == 1'b0) begin
        vis_r <= {WIDTH{1'b0}};
      end else if (wr_en == 1'b1) begin
        vis_r <= din;
      end else begin
        vis_r <= vis_r;
      end
    end
  end else begin : g_shadow
    logic [WIDTH-1:0] shadow_r;

    // Staged port: writes fill the shadow, commit publishes it (dirty or not)
    always_ff @(posedge clk) begin
      if (reset == 1'b0) begin
        shadow_r <= {WIDTH{1'b0}};
        vis_r    <= {WIDTH{1'b0}};
      end else begin
        if (wr_en == 1'b1) begin
          shadow_r <= din;
        end else begin
          shadow_r <= shadow_r;
        end
        if (commit == 1'b1) begin
          vis_r <= shadow_r;
        end else begin
          vis_r <= vis_r;
        end
      end
    end
  end

  assign q = vis_r;

endmodule

// File: rtl/pico_out_bank.sv
// PicoBlaze output-port bank with atomic commit of the staged RTC fields and
// a valid/ack handshake towards the RTC write sequencer.
module pico_out_bank
  import pico_out_bank_pkg::*;
#(
  parameter int                  WIDTH       = 8,
  parameter int                  N_PORTS     = N_PORTS_DEFAULT,
  parameter int                  ID_WIDTH    = 8,
  parameter logic [ID_WIDTH-1:0] COMMIT_ID   = ID_WIDTH'(PORT_COMMIT),
  parameter logic [N_PORTS-1:0]  DIRECT_MASK = N_PORTS'(DEFAULT_DIRECT_MASK)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         out_port,
  input  logic [ID_WIDTH-1:0]      port_id,
  input  logic                     write_strobe,
  output logic [N_PORTS*WIDTH-1:0] data_out,
  output logic                     update_valid,
  output logic [N_PORTS-1:0]       update_mask,
  input  logic                     update_ack,
  output logic                     overrun
);

  // The commit address must not alias a port, and every port must be addressable
  if ((int'(COMMIT_ID) < N_PORTS) || (N_PORTS > (2 ** ID_WIDTH))) begin : g_cfg_err
    $error("pico_out_bank: COMMIT_ID must be >= N_PORTS and N_PORTS <= 2**ID_WIDTH");
  end

  logic [N_PORTS-1:0] wr_sel_s;
  logic               is_commit_s;
  logic [N_PORTS-1:0] dirty_nxt_s;
  logic [N_PORTS-1:0] dirty_r;
  logic               update_valid_r;
  logic [N_PORTS-1:0] update_mask_r;
  logic               overrun_r;

  // Address decode: one-hot port write select and the commit strobe
  always_comb begin
    wr_sel_s    = {N_PORTS{1'b0}};
    is_commit_s = 1'b0;
    if (write_strobe == 1'b1) begin
      is_commit_s = (port_id == COMMIT_ID);
      for (int i = 0; i < N_PORTS; i++) begin
        wr_sel_s[i] = (port_id == ID_WIDTH'(i));
      end
    end else begin
      wr_sel_s    = {N_PORTS{1'b0}};
      is_commit_s = 1'b0;
    end
  end

  // Dirty tracking covers staged ports only; a commit hands it off and clears it
  always_comb begin
    dirty_nxt_s = dirty_r;
    if (is_commit_s == 1'b1) begin
      dirty_nxt_s = {N_PORTS{1'b0}};
    end else begin
      dirty_nxt_s = dirty_r | (wr_sel_s & ~DIRECT_MASK);
    end
  end

  // Commit handshake: newest commit always wins; overrun flags an unconsumed one
  always_ff @(posedge clk) begin
    if (reset == 1'b0) begin
      dirty_r        <= {N_PORTS{1'b0}};
      update_valid_r <= 1'b0;
      update_mask_r  <= {N_PORTS{1'b0}};
      overrun_r      <= 1'b0;
    end else begin
      dirty_r <= dirty_nxt_s;
      if (is_commit_s == 1'b1) begin
        update_valid_r <= 1'b1;
        update_mask_r  <= dirty_r;
        if ((update_valid_r == 1'b1) && (update_ack == 1'b0)) begin
          overrun_r <= 1'b1;
        end else begin
          overrun_r <= overrun_r;
        end
      end else if ((update_valid_r == 1'b1) && (update_ack == 1'b1)) begin
        update_valid_r <= 1'b0;
        update_mask_r  <= {N_PORTS{1'b0}};
        overrun_r      <= overrun_r;
      end else begin
        update_valid_r <= update_valid_r;
        update_mask_r  <= update_mask_r;
        overrun_r      <= overrun_r;
      end
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    pico_port_reg #(
      .WIDTH  (WIDTH),
      .DIRECT (DIRECT_MASK[i])
    ) u_port_reg (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_sel_s[i]),
      .commit (is_commit_s),
      .din    (out_port),
      .q      (data_out[i*WIDTH +: WIDTH])
    );
  end

  assign update_valid = update_valid_r;
  assign update_mask  = update_mask_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_pico_out_bank.sv
// Bench for pico_out_bank: directed scenarios plus a random run checked
// against a behavioural model of the port bank.
module tb_pico_out_bank;
  import pico_out_bank_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  out_port;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic [95:0] data_out;
  logic        update_valid;
  logic [11:0] update_mask;
  logic        update_ack;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  shadow_m [12];
  logic [7:0]  vis_m    [12];
  logic [11:0] dirty_m;
  logic        valid_m;
  logic [11:0] mask_m;
  logic        overrun_m;

  localparam logic [11:0] DIRECT_M = 12'hE00;

  pico_out_bank dut (
    .clk          (clk),
    .reset        (reset),
    .out_port     (out_port),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .data_out     (data_out),
    .update_valid (update_valid),
    .update_mask  (update_mask),
    .update_ack   (update_ack),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] model_data();
    logic [95:0] v;
    for (int i = 0; i < 12; i++) v[i*8 +: 8] = vis_m[i];
    return v;
  endfunction

  task automatic model_step(input logic s, input logic [7:0] id, input logic [7:0] d,
                            input logic a, input logic r);
    if (!r) begin
      for (int i = 0; i < 12; i++) begin shadow_m[i] = 8'h00; vis_m[i] = 8'h00; end
      dirty_m = 12'h000; valid_m = 1'b0; mask_m = 12'h000; overrun_m = 1'b0;
    end else if (s && id < 8'd12) begin
      if (DIRECT_M[id]) vis_m[id] = d;
      else begin shadow_m[id] = d; dirty_m[id] = 1'b1; end
      if (a && valid_m) begin valid_m = 1'b0; mask_m = 12'h000; end
    end else if (s && id == 8'hFF) begin
      for (int i = 0; i < 12; i++) if (!DIRECT_M[i]) vis_m[i] = shadow_m[i];
      if (valid_m && !a) overrun_m = 1'b1;
      mask_m = dirty_m; dirty_m = 12'h000; valid_m = 1'b1;
    end else if (a && valid_m) begin
      valid_m = 1'b0; mask_m = 12'h000;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and settle on the falling edge
  task automatic step(input logic s, input logic [7:0] id, input logic [7:0] d,
                      input logic a, input logic r);
    write_strobe = s; port_id = id; out_port = d; update_ack = a; reset = r;
    @(posedge clk);
    model_step(s, id, d, a, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 8'h00, 8'h12, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    total++; if (data_out !== 96'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_out); end
    total++; if (update_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", update_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (update_mask !== 12'h000) begin bad++; $display("FAIL reset_mask got=%h exp=000", update_mask); end
  endtask

  task automatic test_staged_write();
    step(1'b1, 8'(PORT_SEG), 8'h12, 1'b0, 1'b1);
    step(1'b1, 8'(PORT_HORA), 8'h34, 1'b0, 1'b1);
    total++; if (data_out[PORT_SEG*8 +: 8] !== 8'h00) begin bad++; $display("FAIL staged_seg got=%h exp=00", data_out[PORT_SEG*8 +: 8]); end
    total++; if (data_out[PORT_HORA*8 +: 8] !== 8'h00) begin bad++; $display("FAIL staged_hora got=%h exp=00", data_out[PORT_HORA*8 +: 8]); end
    total++; if (update_valid !== 1'b0) begin bad++; $display("FAIL staged_valid got=%b exp=0", update_valid); end
    step(1'b1, 8'hFF, 8'h99, 1'b0, 1'b1);
    total++; if (data_out[PORT_SEG*8 +: 8] !== 8'h12) begin bad++; $display("FAIL commit_seg got=%h exp=12", data_out[PORT_SEG*8 +: 8]); end
    total++; if (data_out[PORT_HORA*8 +: 8] !== 8'h34) begin bad++; $display("FAIL commit_hora got=%h exp=34", data_out[PORT_HORA*8 +: 8]); end
    total++; if (update_valid !== 1'b1) begin bad++; $display("FAIL commit_valid got=%b exp=1", update_valid); end
    total++; if (update_mask !== 12'h005) begin bad++; $display("FAIL commit_mask got=%h exp=005", update_mask); end
  endtask

  task automatic test_direct();
    step(1'b1, 8'(PORT_FLECHA), 8'hA5, 1'b0, 1'b1);
    total++; if (data_out[PORT_FLECHA*8 +: 8] !== 8'hA5) begin bad++; $display("FAIL direct_flecha got=%h exp=a5", data_out[PORT_FLECHA*8 +: 8]); end
    total++; if (update_mask !== 12'h005) begin bad++; $display("FAIL direct_mask got=%h exp=005", update_mask); end
  endtask

  task automatic test_handshake();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      total++; if (update_valid !== 1'b1) begin bad++; $display("FAIL hs_hold%0d got=%b exp=1", k, update_valid); end
    end
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    total++; if (update_valid !== 1'b0) begin bad++; $display("FAIL hs_ack_valid got=%b exp=0", update_valid); end
    total++; if (update_mask !== 12'h000) begin bad++; $display("FAIL hs_ack_mask got=%h exp=000", update_mask); end
  endtask

  task automatic test_overrun();
    step(1'b1, 8'(PORT_MIN), 8'h56, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'(PORT_MIN), 8'h78, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    total++; if (data_out[PORT_MIN*8 +: 8] !== 8'h78) begin bad++; $display("FAIL ovr_min got=%h exp=78", data_out[PORT_MIN*8 +: 8]); end
    total++; if (update_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", update_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++; if (update_mask !== port_bit(PORT_MIN)) begin bad++; $display("FAIL ovr_mask got=%h exp=002", update_mask); end
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ack_commit_ovr got=%b exp=0", overrun); end
    total++; if (update_valid !== 1'b1) begin bad++; $display("FAIL ack_commit_valid got=%b exp=1", update_valid); end
  endtask

  task automatic test_out_of_range();
    step(1'b1, 8'(PORT_DIA), 8'h3C, 1'b0, 1'b1);
    step(1'b1, 8'h0C, 8'hEE, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    total++; if (update_mask !== port_bit(PORT_DIA)) begin bad++; $display("FAIL oor_mask got=%h exp=008", update_mask); end
    total++; if (data_out !== model_data()) begin bad++; $display("FAIL oor_data got=%h exp=%h", data_out, model_data()); end
  endtask

  task automatic test_mid_reset();
    total++; if (update_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b exp=1", update_valid); end
    step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    total++; if ({data_out, update_valid, update_mask, overrun} !== 110'h0) begin
      bad++; $display("FAIL mid_reset got=%h/%b/%h/%b exp=0", data_out, update_valid, update_mask, overrun);
    end
  endtask

  task automatic test_random();
    logic [7:0] id;
    int r;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 15);
      if (r < 12) id = 8'(r);
      else if (r < 14) id = 8'hFF;
      else id = 8'($urandom_range(12, 254));
      step(1'($urandom_range(0, 3) != 0), id, 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 63) != 0));
      total++;
      if ({data_out, update_valid, update_mask, overrun} !== {model_data(), valid_m, mask_m, overrun_m}) begin
        bad++;
        $display("FAIL rand%0d got=%h/%b/%h/%b exp=%h/%b/%h/%b", k, data_out, update_valid, update_mask,
                 overrun, model_data(), valid_m, mask_m, overrun_m);
      end
    end
  endtask

  initial begin
    reset = 1'b0; write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00; update_ack = 1'b0;
    test_reset();
    test_staged_write();
    test_direct();
    test_handshake();
    test_overrun();
    test_out_of_range();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
